// File: rtl/fp_mlt_pipe.sv
// Pipelined [s][exp][mant] multiplier: denormals flush to zero, RNE or truncate,
// saturating overflow / flushing underflow, valid/ready with whole-pipeline stall.
module fp_mlt_pipe #(
  parameter int    EXP     = 8,
  parameter int    MANT    = 7,
  parameter int    WIDTH   = EXP + MANT + 1,
  parameter int    LATENCY = 2,
  parameter string ROUND   = "RNE"
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow
);

  localparam int BIAS = 2**(EXP-1) - 1;
  localparam int PW   = 2 * (MANT + 1);
  localparam int EW   = EXP + 2;
  localparam bit RNE  = (ROUND == "RNE");
  localparam logic [EW-1:0] BIAS_W = EW'(BIAS);

  // Exponent sum is kept two's complement in EW bits so under/overflow stay visible.
  typedef struct packed {
    logic          sign;
    logic          zero;
    logic [PW-1:0] prod;
    logic [EW-1:0] esum;
  } s1_t;

  logic en;
  assign en         = ~result_valid | result_ready;
  assign data_ready = en;

  s1_t s1_in;

  always_comb begin
    s1_in.sign = dataa[WIDTH-1] ^ datab[WIDTH-1];
    s1_in.zero = (dataa[WIDTH-2 -: EXP] == '0) || (datab[WIDTH-2 -: EXP] == '0);
    s1_in.prod = PW'({1'b1, dataa[MANT-1:0]}) * PW'({1'b1, datab[MANT-1:0]});
    s1_in.esum = EW'(dataa[WIDTH-2 -: EXP]) + EW'(datab[WIDTH-2 -: EXP]) - BIAS_W;
  end

  logic tail_vld;
  s1_t  tail;

  if (LATENCY == 1) begin : g_comb
    assign tail_vld = data_valid;
    assign tail     = s1_in;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld;
    s1_t                dat [LATENCY-1];

    always_ff @(posedge clock) begin
      if (clock_sreset) begin
        vld <= '0;
      end else if (en) begin
        vld[0] <= data_valid;
        for (int i = 1; i < LATENCY - 1; i++) vld[i] <= vld[i-1];
      end
    end

    // NOTE: datapath registers carry no reset; only the valid bits decide what is live.
    always_ff @(posedge clock) begin
      if (en) begin
        dat[0] <= s1_in;
        for (int i = 1; i < LATENCY - 1; i++) dat[i] <= dat[i-1];
      end
    end

    assign tail_vld = vld[LATENCY-2];
    assign tail     = dat[LATENCY-2];
  end

  logic            msb, guard, sticky, inc, carry;
  logic [PW-2:0]   norm;
  logic [MANT-1:0] frac;
  logic [MANT:0]   frac_r;
  logic [EW-1:0]   er;
  logic [WIDTH-1:0] res_c;
  logic            ovf_c, unf_c;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    res_c  = '0;
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    msb    = tail.prod[PW-1];
    norm   = msb ? tail.prod[PW-2:0] : {tail.prod[PW-3:0], 1'b0};
    frac   = norm[PW-2 -: MANT];
    guard  = norm[MANT];
    sticky = |norm[MANT-1:0];
    inc    = RNE && guard && (sticky || frac[0]);
    frac_r = {1'b0, frac} + (MANT+1)'(inc);
    carry  = frac_r[MANT];
    er     = tail.esum + EW'(msb) + EW'(carry);
    if (tail.zero) begin
      res_c = '0;
    end else if (er[EW-1] || er == '0) begin
      unf_c = 1'b1;
    end else if (er[EXP]) begin
      res_c = {tail.sign, {(WIDTH-1){1'b1}}};
      ovf_c = 1'b1;
    end else begin
      res_c = {tail.sign, er[EXP-1:0], frac_r[MANT-1:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      result_valid <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (en) begin
      result_valid <= tail_vld;
      result       <= res_c;
      overflow     <= tail_vld & ovf_c;
      underflow    <= tail_vld & unf_c;
    end
  end

endmodule

// File: tb/tb_fp_mlt_pipe.sv
// Bench for fp_mlt_pipe: five lanes (L2 RNE, L2 TRUNC, L1, L3, L4) share operands,
// each with its own handshake and scoreboard queue of {overflow, underflow, result}.
module tb_fp_mlt_pipe;

  localparam int NL = 5;

  logic           clock = 1'b0;
  logic           clock_sreset;
  logic [NL-1:0]  dv, rr;
  logic [15:0]    dataa, datab;
  wire  [NL-1:0]  dr, rv, ovf, unf;
  wire  [15:0]    res [NL];

  always #5 clock = ~clock;

  fp_mlt_pipe #(.LATENCY(2), .ROUND("RNE")) u_l2_rne (
    .clock(clock), .clock_sreset(clock_sreset), .data_valid(dv[0]), .data_ready(dr[0]),
    .dataa(dataa), .datab(datab), .result_valid(rv[0]), .result_ready(rr[0]),
    .result(res[0]), .overflow(ovf[0]), .underflow(unf[0]));
  fp_mlt_pipe #(.LATENCY(2), .ROUND("TRUNC")) u_l2_trunc (
    .clock(clock), .clock_sreset(clock_sreset), .data_valid(dv[1]), .data_ready(dr[1]),
    .dataa(dataa), .datab(datab), .result_valid(rv[1]), .result_ready(rr[1]),
    .result(res[1]), .overflow(ovf[1]), .underflow(unf[1]));
  fp_mlt_pipe #(.LATENCY(1), .ROUND("RNE")) u_l1 (
    .clock(clock), .clock_sreset(clock_sreset), .data_valid(dv[2]), .data_ready(dr[2]),
    .dataa(dataa), .datab(datab), .result_valid(rv[2]), .result_ready(rr[2]),
    .result(res[2]), .overflow(ovf[2]), .underflow(unf[2]));
  fp_mlt_pipe #(.LATENCY(3), .ROUND("RNE")) u_l3 (
    .clock(clock), .clock_sreset(clock_sreset), .data_valid(dv[3]), .data_ready(dr[3]),
    .dataa(dataa), .datab(datab), .result_valid(rv[3]), .result_ready(rr[3]),
    .result(res[3]), .overflow(ovf[3]), .underflow(unf[3]));
  fp_mlt_pipe #(.LATENCY(4), .ROUND("RNE")) u_l4 (
    .clock(clock), .clock_sreset(clock_sreset), .data_valid(dv[4]), .data_ready(dr[4]),
    .dataa(dataa), .datab(datab), .result_valid(rv[4]), .result_ready(rr[4]),
    .result(res[4]), .overflow(ovf[4]), .underflow(unf[4]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [17:0] rne;
    logic [17:0] trn;
  } vec_t;

  typedef struct {
    logic [17:0] exp;
    int          cyc;
    int          stl;
  } sb_t;

  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stall_cnt [NL];
  logic [17:0] exp_cur [NL];
  logic [17:0] out_prev [NL];
  logic [NL-1:0] stalled_prev, accepted, popped, dr_seen, rv_seen;
  sb_t         sbq [NL][$];
  vec_t        vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(input int i);
    case (i)
      2:       return 1;
      3:       return 3;
      4:       return 4;
      default: return 2;
    endcase
  endfunction

  // Reference product for EXP=8/MANT=7; returns {overflow, underflow, result}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input bit rne);
    int   ea, eb, e, p, kept, rem;
    logic s;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    if (ea == 0 || eb == 0) return 18'h0;
    s = a[15] ^ b[15];
    p = (128 + int'(a[6:0])) * (128 + int'(b[6:0]));
    e = ea + eb - 127;
    if (p >= 32768) e++;
    else p = p * 2;
    kept = p / 256;
    rem  = p % 256;
    if (rne && (rem > 128 || (rem == 128 && (kept % 2) == 1))) kept++;
    if (kept == 256) begin
      kept = 128;
      e++;
    end
    if (e <= 0) return {2'b01, 16'h0000};
    if (e >= 256) return {2'b10, s, 15'h7FFF};
    return {2'b00, s, e[7:0], kept[6:0]};
  endfunction

  // One clock cycle: observe handshakes at negedge+1, then advance to the next negedge.
  task automatic tick();
    sb_t e;
    #1;
    accepted = '0;
    popped   = '0;
    dr_seen  = dr;
    rv_seen  = rv;
    if (clock_sreset) begin
      for (int i = 0; i < NL; i++) sbq[i].delete();
      stalled_prev = '0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (stalled_prev[i]) begin
          check($sformatf("lane%0d_hold_valid", i), 32'(rv[i]), 32'd1);
          check($sformatf("lane%0d_hold_output", i), 32'({ovf[i], unf[i], res[i]}), 32'(out_prev[i]));
        end
        if (rv[i] && rr[i]) begin
          popped[i] = 1'b1;
          check($sformatf("lane%0d_output_expected", i), 32'(sbq[i].size() > 0), 32'd1);
          if (sbq[i].size() > 0) begin
            e = sbq[i].pop_front();
            check($sformatf("lane%0d_result", i), 32'(res[i]), 32'(e.exp[15:0]));
            check($sformatf("lane%0d_flags", i), 32'({ovf[i], unf[i]}), 32'(e.exp[17:16]));
            check($sformatf("lane%0d_latency", i), 32'(cyc - e.cyc), 32'(lat(i) + stall_cnt[i] - e.stl));
          end
        end
        if (dv[i] && dr[i]) begin
          accepted[i] = 1'b1;
          e.exp = exp_cur[i];
          e.cyc = cyc;
          e.stl = stall_cnt[i];
          sbq[i].push_back(e);
        end
        if (rv[i] && !rr[i]) stall_cnt[i]++;
        stalled_prev[i] = rv[i] & ~rr[i];
        out_prev[i]     = {ovf[i], unf[i], res[i]};
      end
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    dv = dv & ~accepted;
  endtask

  // Offer one operand pair to every lane and hold it until all lanes have taken it.
  task automatic drive_pair(input logic [15:0] a, input logic [15:0] b,
                            input logic [17:0] e_rne, input logic [17:0] e_trn,
                            input bit rand_ready);
    int guard;
    dataa = a;
    datab = b;
    for (int i = 0; i < NL; i++) exp_cur[i] = (i == 1) ? e_trn : e_rne;
    dv    = '1;
    guard = 0;
    while (dv != '0 && guard < 100) begin
      for (int i = 0; i < NL; i++) rr[i] = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      tick();
      guard++;
    end
    if (dv != '0) check("accept_timeout", 32'(dv), 32'd0);
  endtask

  task automatic drain();
    int guard;
    int pending;
    dv    = '0;
    rr    = '1;
    guard = 0;
    pending = 1;
    while (pending != 0 && guard < 50) begin
      tick();
      guard++;
      pending = 0;
      for (int i = 0; i < NL; i++) pending += sbq[i].size();
    end
    for (int i = 0; i < NL; i++)
      check($sformatf("lane%0d_missing_outputs", i), 32'(sbq[i].size()), 32'd0);
  endtask

  initial begin
    int idx;
    logic [15:0] a, b;

    vecs[0]  = '{16'h3FC0, 16'h3FC0, {2'b00, 16'h4010}, {2'b00, 16'h4010}};
    vecs[1]  = '{16'hBF80, 16'h4040, {2'b00, 16'hC040}, {2'b00, 16'hC040}};
    vecs[2]  = '{16'h3FC1, 16'h3FC1, {2'b00, 16'h4012}, {2'b00, 16'h4011}};
    vecs[3]  = '{16'h3F81, 16'h3F81, {2'b00, 16'h3F82}, {2'b00, 16'h3F82}};
    vecs[4]  = '{16'h7F00, 16'h4000, {2'b00, 16'h7F80}, {2'b00, 16'h7F80}};
    vecs[5]  = '{16'h7F80, 16'h4000, {2'b10, 16'h7FFF}, {2'b10, 16'h7FFF}};
    vecs[6]  = '{16'h0080, 16'h3F00, {2'b01, 16'h0000}, {2'b01, 16'h0000}};
    vecs[7]  = '{16'h8000, 16'h4040, {2'b00, 16'h0000}, {2'b00, 16'h0000}};
    vecs[8]  = '{16'h0001, 16'h4000, {2'b00, 16'h0000}, {2'b00, 16'h0000}};
    vecs[9]  = '{16'h3FB5, 16'h3FB5, {2'b00, 16'h4000}, {2'b00, 16'h3FFF}};
    vecs[10] = '{16'h7FB5, 16'h3FB5, {2'b10, 16'h7FFF}, {2'b00, 16'h7FFF}};
    vecs[11] = '{16'h00B5, 16'h3F35, {2'b00, 16'h0080}, {2'b01, 16'h0000}};
    vecs[12] = '{16'hC000, 16'hC000, {2'b00, 16'h4080}, {2'b00, 16'h4080}};
    vecs[13] = '{16'hFF80, 16'h4000, {2'b10, 16'hFFFF}, {2'b10, 16'hFFFF}};
    vecs[14] = '{16'h8080, 16'h3F00, {2'b01, 16'h0000}, {2'b01, 16'h0000}};
    vecs[15] = '{16'h3FC0, 16'h3FAE, {2'b00, 16'h4002}, {2'b00, 16'h4002}};
    vecs[16] = '{16'h3FC0, 16'h3FB2, {2'b00, 16'h4006}, {2'b00, 16'h4005}};

    for (int i = 0; i < NL; i++) begin
      stall_cnt[i] = 0;
      exp_cur[i]   = '0;
      out_prev[i]  = '0;
    end
    stalled_prev = '0;
    clock_sreset = 1'b1;
    dv    = '0;
    rr    = '1;
    dataa = '0;
    datab = '0;

    repeat (3) @(negedge clock);
    #1;
    for (int i = 0; i < NL; i++) begin
      check($sformatf("lane%0d_reset_valid", i), 32'(rv[i]), 32'd0);
      check($sformatf("lane%0d_reset_result", i), 32'(res[i]), 32'd0);
      check($sformatf("lane%0d_reset_flags", i), 32'({ovf[i], unf[i]}), 32'd0);
    end
    clock_sreset = 1'b0;
    @(negedge clock);
    #1;
    check("ready_after_reset", 32'(dr), 32'h1F);

    // Directed vectors, back to back with the output always accepted.
    foreach (vecs[k]) drive_pair(vecs[k].a, vecs[k].b, vecs[k].rne, vecs[k].trn, 1'b0);
    drain();

    // Six-beat stream on the L2 lane with result_ready low for cycles 3..7.
    idx = 0;
    for (int c = 1; c <= 14; c++) begin
      rr = (c >= 3 && c <= 7) ? 5'h00 : 5'h1F;
      if (idx < 6) begin
        dataa      = vecs[idx].a;
        datab      = vecs[idx].b;
        exp_cur[0] = vecs[idx].rne;
        dv         = 5'h01;
      end else begin
        dv = '0;
      end
      tick();
      if (accepted[0]) idx++;
      if (c >= 3 && c <= 7) begin
        check("bp_data_ready_low", 32'(dr_seen[0]), 32'd0);
        check("bp_held_first_result", 32'(out_prev[0][15:0]), 32'h4010);
      end
      if (c >= 8 && c <= 13) check("bp_no_gap_after_release", 32'(popped[0]), 32'd1);
    end
    check("bp_beats_accepted", 32'(idx), 32'd6);
    drain();

    // Reset with two beats in flight on the L4 lane; a beat offered during reset is ignored.
    rr = '1;
    for (int k = 0; k < 2; k++) begin
      dataa      = vecs[k].a;
      datab      = vecs[k].b;
      exp_cur[4] = vecs[k].rne;
      dv         = 5'h10;
      tick();
    end
    clock_sreset = 1'b1;
    dataa        = vecs[2].a;
    datab        = vecs[2].b;
    dv           = 5'h10;
    tick();
    clock_sreset = 1'b0;
    dv           = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midreset_no_output", 32'(rv_seen), 32'd0);
      if (k == 0) check("midreset_ready", 32'(dr_seen), 32'h1F);
    end
    drain();

    // Random operands and random downstream backpressure across all lanes.
    for (int n = 0; n < 10000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(15) == 0) a[14:7] = 8'h00;
      if ($urandom_range(15) == 0) b[14:7] = 8'hFF;
      drive_pair(a, b, model(a, b, 1'b1), model(a, b, 1'b0), 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
